// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronises and debounces the two raw sensors, then issues
// single-cycle credit or reject pulses with a release-plus-gap lockout between coins.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic coin_one_raw,
    input  logic coin_two_raw,
    input  logic accept_en,
    output logic rupee_one,
    output logic rupee_two,
    output logic coin_reject,
    output logic busy
);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > GAP_CYCLES) ? DEBOUNCE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        WAIT_RELEASE,
        GAP
    } state_t;

    logic [1:0]       meta_q;
    logic [1:0]       sync_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             type_q, type_d;
    logic             one_q, one_d;
    logic             two_q, two_d;
    logic             rej_q, rej_d;
    logic             busy_q;

    logic             s1, s2;
    logic             latched_hi, other_hi;
    logic [CNT_W-1:0] cnt_inc;

    assign s1         = sync_q[0];
    assign s2         = sync_q[1];
    // type_q = 0 means the ₹1 sensor is being debounced, 1 means the ₹2 sensor
    assign latched_hi = type_q ? s2 : s1;
    assign other_hi   = type_q ? s1 : s2;
    assign cnt_inc    = cnt_q + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 2'b00;
            sync_q <= 2'b00;
        end else begin
            meta_q <= {coin_two_raw, coin_one_raw};
            sync_q <= meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        one_d   = 1'b0;
        two_d   = 1'b0;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s1 ^ s2) begin
                    state_d = DEBOUNCE;
                    type_d  = s2;
                    cnt_d   = CNT_ONE;
                end else if (s1 && s2) begin
                    rej_d   = 1'b1;
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            DEBOUNCE: begin
                if (!latched_hi) begin
                    // Dropped before the decision edge: a glitch, not a coin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (other_hi) begin
                    rej_d   = 1'b1;
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    one_d   = accept_en && !type_q;
                    two_d   = accept_en && type_q;
                    rej_d   = !accept_en;
                    state_d = WAIT_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_RELEASE: begin
                if (s1 || s2) begin
                    cnt_d = '0;
                end else if (cnt_inc == DEB_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                if (cnt_inc == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = WAIT_RELEASE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset parks in WAIT_RELEASE so a coin held across reset is never credited
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            type_q  <= 1'b0;
            one_q   <= 1'b0;
            two_q   <= 1'b0;
            rej_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            type_q  <= type_d;
            one_q   <= one_d;
            two_q   <= two_d;
            rej_q   <= rej_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign rupee_one   = one_q;
    assign rupee_two   = two_q;
    assign coin_reject = rej_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: a sample-stream scanning model predicts pulses and busy.
module tb_coin_acceptor;
    localparam int D    = 4;
    localparam int G    = 2;
    localparam int NMAX = 4000;

    logic clk = 1'b0;
    logic reset_n, coin_one_raw, coin_two_raw, accept_en;
    logic rupee_one, rupee_two, coin_reject, busy;

    coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .coin_one_raw(coin_one_raw),
        .coin_two_raw(coin_two_raw),
        .accept_en   (accept_en),
        .rupee_one   (rupee_one),
        .rupee_two   (rupee_two),
        .coin_reject (coin_reject),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int edge_no;
        int kind;  // 0 rupee_one, 1 rupee_two, 2 coin_reject
    } pulse_t;

    bit     st_a[NMAX], st_b[NMAX], st_acc[NMAX], st_rn[NMAX];
    bit     sa[NMAX], sb[NMAX], busy_exp[NMAX];
    int     n_edges  = 0;
    int     n_checks = 0;
    int     n_fail   = 0;
    pulse_t exp_q[$];
    string  kind_name[3];

    task automatic put(input int len, input bit a, input bit b, input bit acc, input bit rn);
        for (int i = 0; i < len; i++) begin
            if (n_edges < NMAX) begin
                st_a[n_edges]   = a;
                st_b[n_edges]   = b;
                st_acc[n_edges] = acc;
                st_rn[n_edges]  = rn;
                n_edges++;
            end
        end
    endtask

    task automatic push(input int kind, input int e);
        pulse_t pe;
        pe.edge_no = e;
        pe.kind    = kind;
        exp_q.push_back(pe);
    endtask

    function automatic bit smp(input bit ty, input int e);
        return ty ? sb[e] : sa[e];
    endfunction

    // Sensor value seen by the decision logic at edge e is the raw value two edges
    // earlier, zeroed if either of those edges was a reset edge.
    task automatic build_model();
        int p, run, q, g;
        bit idle_mode, ty;
        for (int e = 0; e < n_edges; e++) begin
            if (e < 2) begin
                sa[e] = 1'b0;
                sb[e] = 1'b0;
            end else if (!st_rn[e-1] || !st_rn[e-2]) begin
                sa[e] = 1'b0;
                sb[e] = 1'b0;
            end else begin
                sa[e] = st_a[e-2];
                sb[e] = st_b[e-2];
            end
            busy_exp[e] = 1'b1;
        end
        p = 0;
        idle_mode = 1'b0;
        while (p < n_edges) begin
            if (!st_rn[p]) begin
                p++;
                idle_mode = 1'b0;
            end else if (!idle_mode) begin
                // need D consecutive all-low samples, then G ignored edges
                run = 0;
                while (p < n_edges && st_rn[p] && run < D) begin
                    run = (sa[p] || sb[p]) ? 0 : run + 1;
                    p++;
                end
                if (run == D) begin
                    g = 0;
                    while (p < n_edges && st_rn[p] && g < G) begin
                        g++;
                        p++;
                    end
                    if (g == G) begin
                        busy_exp[p-1] = 1'b0;
                        idle_mode = 1'b1;
                    end
                end
            end else if (!sa[p] && !sb[p]) begin
                busy_exp[p] = 1'b0;
                p++;
            end else if (sa[p] && sb[p]) begin
                push(2, p);
                p++;
                idle_mode = 1'b0;
            end else begin
                ty  = sb[p];
                run = 1;
                q   = p + 1;
                while (run < D && q < n_edges && st_rn[q] && smp(ty, q) && !smp(!ty, q)) begin
                    run++;
                    q++;
                end
                if (run == D) begin
                    push(st_acc[q-1] ? int'(ty) : 2, q - 1);
                    p = q;
                    idle_mode = 1'b0;
                end else if (q >= n_edges || !st_rn[q]) begin
                    p = q;
                end else if (smp(ty, q)) begin
                    push(2, q);
                    p = q + 1;
                    idle_mode = 1'b0;
                end else begin
                    busy_exp[q] = 1'b0;
                    p = q + 1;
                end
            end
        end
    endtask

    task automatic drive(input int e);
        reset_n      = st_rn[e];
        coin_one_raw = st_a[e];
        coin_two_raw = st_b[e];
        accept_en    = st_acc[e];
    endtask

    initial begin
        pulse_t   pe;
        logic [2:0] pulses;
        logic [2:0] want;
        int r, len;
        bit acc;
        kind_name[0] = "rupee_one";
        kind_name[1] = "rupee_two";
        kind_name[2] = "coin_reject";

        // directed scenarios
        put(3, 0, 0, 1, 0);  put(12, 0, 0, 1, 1);                        // reset, release
        put(10, 1, 0, 1, 1); put(15, 0, 0, 1, 1);                        // clean ₹1
        put(3, 0, 1, 1, 1);  put(12, 0, 0, 1, 1);                        // short glitch
        put(6, 1, 1, 1, 1);  put(15, 0, 0, 1, 1);                        // both at once
        put(2, 1, 0, 1, 1);  put(4, 1, 1, 1, 1); put(15, 0, 0, 1, 1);    // second rises mid-debounce
        put(10, 0, 1, 0, 1); put(15, 0, 0, 1, 1);                        // accept_en low
        put(3, 1, 0, 1, 0);  put(20, 1, 0, 1, 1); put(10, 0, 0, 1, 1);   // coin held across reset
        put(10, 1, 0, 1, 1); put(15, 0, 0, 1, 1);
        put(5, 1, 0, 1, 1);  put(1, 1, 0, 1, 0); put(4, 1, 0, 1, 1);     // reset on decision edge
        put(15, 0, 0, 1, 1);
        put(10, 0, 1, 1, 1); put(15, 0, 0, 1, 1);                        // clean ₹2
        // randomized bouncing traffic
        repeat (150) begin
            r   = $urandom_range(0, 99);
            len = $urandom_range(1, 12);
            acc = 1'($urandom_range(0, 1));
            if (r < 4)       put($urandom_range(1, 3), 0, 0, acc, 0);
            else if (r < 40) put(len, 0, 0, acc, 1);
            else if (r < 65) put(len, 1, 0, acc, 1);
            else if (r < 90) put(len, 0, 1, acc, 1);
            else             put(len, 1, 1, acc, 1);
        end
        put(30, 0, 0, 1, 1);

        build_model();

        drive(0);
        fork
            begin
                for (int e = 1; e < n_edges; e++) begin
                    @(posedge clk);
                    #1;
                    drive(e);
                end
            end
            begin
                for (int e = 0; e < n_edges; e++) begin
                    @(negedge clk);
                    while (exp_q.size() > 0 && exp_q[0].edge_no < e) begin
                        pe = exp_q.pop_front();
                        n_checks++;
                        n_fail++;
                        $display("FAIL missing_pulse: edge %0d got no pulse, required %s",
                                 pe.edge_no, kind_name[pe.kind]);
                    end
                    n_checks++;
                    if (busy !== busy_exp[e]) begin
                        n_fail++;
                        $display("FAIL busy: edge %0d got %b, required %b", e, busy, busy_exp[e]);
                    end
                    pulses = {coin_reject, rupee_two, rupee_one};
                    if (pulses !== 3'b000) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_pulse: edge %0d got {rej,two,one}=%b, required 000",
                                     e, pulses);
                        end else begin
                            pe   = exp_q.pop_front();
                            want = 3'b001 << pe.kind;
                            if (pulses !== want || pe.edge_no != e) begin
                                n_fail++;
                                $display("FAIL pulse: edge %0d got {rej,two,one}=%b, required %b at edge %0d",
                                         e, pulses, want, pe.edge_no);
                            end else begin
                                $display("edge %0d: %s pulse as predicted", e, kind_name[pe.kind]);
                            end
                        end
                    end
                end
            end
        join

        while (exp_q.size() > 0) begin
            pe = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_pulse: edge %0d got no pulse, required %s",
                     pe.edge_no, kind_name[pe.kind]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
